// File: rtl/axi4_lite_write_master_engine_if.sv
// axi4_lite_write_master_engine_if: command, response and AXI4-Lite AW/W/B signals of the write master engine
//   cmd_*  : one write command (address, prot, data, strobes, per-channel valid delays)
//   rsp_*  : B response, wait count and timeout flag returned to the local side
//   aw*/w*/b* : AXI4-Lite write channels; master modport is the engine, slave modport the far side
interface axi4_lite_write_master_engine_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DELAY_WIDTH = 5
);
  logic cmd_valid;
  logic cmd_ready;
  logic [ADDRESS_WIDTH-1:0] cmd_awaddr;
  logic [2:0] cmd_awprot;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;
  logic [DELAY_WIDTH-1:0] cmd_delay_aw;
  logic [DELAY_WIDTH-1:0] cmd_delay_w;
  logic rsp_valid;
  logic rsp_ready;
  logic [1:0] rsp_bresp;
  logic rsp_timeout;
  logic [15:0] rsp_wait_cycles;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    input cmd_valid, cmd_awaddr, cmd_awprot, cmd_wdata, cmd_wstrb, cmd_delay_aw, cmd_delay_w,
    input rsp_ready, awready, wready, bresp, bvalid,
    output cmd_ready, rsp_valid, rsp_bresp, rsp_timeout, rsp_wait_cycles,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready
  );
  modport slave (
    output cmd_valid, cmd_awaddr, cmd_awprot, cmd_wdata, cmd_wstrb, cmd_delay_aw, cmd_delay_w,
    output rsp_ready, awready, wready, bresp, bvalid,
    input cmd_ready, rsp_valid, rsp_bresp, rsp_timeout, rsp_wait_cycles,
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/axi4_lite_write_master_engine.sv
// axi4_lite_write_master_engine: single-outstanding AXI4-Lite write initiator with per-channel delays and B timeout
//   aclk, areset : clock and synchronous active-high reset
//   bus (master) : command in, response out, AW/W driven, B collected
module axi4_lite_write_master_engine #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DELAY_WIDTH = 5,
  parameter int BRESP_TIMEOUT = 64
) (
  input logic aclk,
  input logic areset,
  axi4_lite_write_master_engine_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} state_t;
  state_t state_q, state_d;
  logic [DELAY_WIDTH-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0] awprot_q, awprot_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [15:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic [1:0] rsp_bresp_q, rsp_bresp_d;
  logic rsp_timeout_q, rsp_timeout_d;
  logic [15:0] rsp_wait_q, rsp_wait_d;
  logic last_wait;
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.awvalid = state_q == ISSUE && aw_cnt_q == '0 && !aw_done_q;
  assign bus.wvalid = state_q == ISSUE && w_cnt_q == '0 && !w_done_q;
  assign bus.bready = state_q == WAIT_RESP;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.awaddr = awaddr_q;
  assign bus.awprot = awprot_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;
  assign bus.rsp_bresp = rsp_bresp_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_wait_cycles = rsp_wait_q;
  assign wait_inc = &wait_cnt_q ? wait_cnt_q : wait_cnt_q + 16'd1;
  // last WAIT_RESP cycle: bready has then been high for BRESP_TIMEOUT cycles
  assign last_wait = 32'(wait_cnt_q) >= 32'(BRESP_TIMEOUT - 1);
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      aw_cnt_q <= '0;
      w_cnt_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wait_cnt_q <= '0;
      rsp_bresp_q <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_wait_q <= '0;
    end else begin
      state_q <= state_d;
      aw_cnt_q <= aw_cnt_d;
      w_cnt_q <= w_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      awaddr_q <= awaddr_d;
      awprot_q <= awprot_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_bresp_q <= rsp_bresp_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_wait_q <= rsp_wait_d;
    end
  end
  always_comb begin
    state_d = state_q;
    aw_cnt_d = aw_cnt_q;
    w_cnt_d = w_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    awaddr_d = awaddr_q;
    awprot_d = awprot_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wait_cnt_d = wait_cnt_q;
    rsp_bresp_d = rsp_bresp_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_wait_d = rsp_wait_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        awaddr_d = bus.cmd_awaddr;
        awprot_d = bus.cmd_awprot;
        wdata_d = bus.cmd_wdata;
        wstrb_d = bus.cmd_wstrb;
        aw_cnt_d = bus.cmd_delay_aw;
        w_cnt_d = bus.cmd_delay_w;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        aw_cnt_d = aw_cnt_q != '0 ? aw_cnt_q - 1'b1 : aw_cnt_q;
        w_cnt_d = w_cnt_q != '0 ? w_cnt_q - 1'b1 : w_cnt_q;
        aw_done_d = aw_done_q | (bus.awvalid & bus.awready);
        w_done_d = w_done_q | (bus.wvalid & bus.wready);
        // done flags include this cycle's handshakes so simultaneous completion moves on at once
        if (aw_done_d && w_done_d) begin
          wait_cnt_d = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        wait_cnt_d = wait_inc;
        if (bus.bvalid) begin
          rsp_bresp_d = bus.bresp;
          rsp_timeout_d = 1'b0;
          rsp_wait_d = wait_cnt_q;
          state_d = RESP;
        end else if (last_wait) begin
          rsp_bresp_d = 2'b10;
          rsp_timeout_d = 1'b1;
          rsp_wait_d = wait_inc;
          state_d = RESP;
        end
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
endmodule

// File: tb/tb_axi4_lite_write_master_engine.sv
// tb_axi4_lite_write_master_engine: randomized and directed checks of the write master engine against a timing model
module tb_axi4_lite_write_master_engine;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  axi4_lite_write_master_engine_if bus ();
  axi4_lite_write_master_engine #(.BRESP_TIMEOUT(TO)) dut (.aclk(clk), .areset(rst), .bus(bus));
  typedef struct {
    int first_aw, first_w, aw_hs, w_hs, first_b, b_cycles, b_hs, first_rsp, done;
    int unstable, rsp_unstable, cmd_bad, issue_wait;
    logic [1:0] bresp;
    logic tmo;
    logic [15:0] wait_c;
    logic ready_after;
    bit expired;
  } obs_t;
  // Offers one command (caller is at a negedge) and plays the slave side; cycle n is the n-th cycle after acceptance.
  task automatic run_txn(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                         input logic [3:0] strb, input int daw, input int dw, input int aws, input int ws,
                         input int bd, input logic [1:0] br, input int rs, input bit late_b, output obs_t o);
    int aw_seen, w_seen, rsp_n;
    logic [18:0] rsp_first;
    o = '{default: 0};
    o.first_aw = -1; o.first_w = -1; o.aw_hs = -1; o.w_hs = -1; o.first_b = -1; o.first_rsp = -1; o.done = -1;
    aw_seen = 0; w_seen = 0; rsp_n = 0; rsp_first = '0;
    bus.cmd_valid = 1'b1; bus.cmd_awaddr = addr; bus.cmd_awprot = prot; bus.cmd_wdata = data; bus.cmd_wstrb = strb;
    bus.cmd_delay_aw = 5'(daw); bus.cmd_delay_w = 5'(dw);
    while (!bus.cmd_ready && o.issue_wait < 50) begin @(negedge clk); o.issue_wait++; end
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      if (bus.cmd_ready) o.cmd_bad++;
      if (bus.awvalid) begin
        if (o.first_aw < 0) o.first_aw = n;
        if (bus.awaddr !== addr || bus.awprot !== prot) o.unstable++;
      end
      if (bus.wvalid) begin
        if (o.first_w < 0) o.first_w = n;
        if (bus.wdata !== data || bus.wstrb !== strb) o.unstable++;
      end
      bus.awready = bus.awvalid && aw_seen >= aws;
      if (bus.awvalid) begin if (bus.awready) o.aw_hs = n; aw_seen++; end
      bus.wready = bus.wvalid && w_seen >= ws;
      if (bus.wvalid) begin if (bus.wready) o.w_hs = n; w_seen++; end
      if (bus.bready) begin if (o.first_b < 0) o.first_b = n; o.b_cycles++; end
      bus.bvalid = bus.bready ? (o.b_cycles - 1 >= bd) : (late_b && o.first_b >= 0);
      bus.bresp = br;
      if (bus.bvalid && bus.bready) o.b_hs++;
      if (bus.rsp_valid) begin
        if (o.first_rsp < 0) begin
          o.first_rsp = n; o.bresp = bus.rsp_bresp; o.tmo = bus.rsp_timeout; o.wait_c = bus.rsp_wait_cycles;
          rsp_first = {bus.rsp_bresp, bus.rsp_timeout, bus.rsp_wait_cycles};
        end else if ({bus.rsp_bresp, bus.rsp_timeout, bus.rsp_wait_cycles} !== rsp_first) o.rsp_unstable++;
        bus.rsp_ready = rsp_n >= rs;
        rsp_n++;
        if (bus.rsp_ready) begin o.done = n; break; end
      end
    end
    if (o.done < 0) o.expired = 1'b1;
    @(negedge clk);
    o.ready_after = bus.cmd_ready;
    bus.rsp_ready = 1'b0; bus.bvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout, bus.awvalid, bus.wvalid, bus.bready} !== 6'b100000) begin miscompares++; $display("FAIL reset.ctrl got %b want 100000", {bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout, bus.awvalid, bus.wvalid, bus.bready}); end
    vectors++; if ({bus.awaddr, bus.awprot, bus.wdata, bus.wstrb, bus.rsp_bresp, bus.rsp_wait_cycles} !== '0) begin miscompares++; $display("FAIL reset.data got %h want 0", {bus.awaddr, bus.awprot, bus.wdata, bus.wstrb, bus.rsp_bresp, bus.rsp_wait_cycles}); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_zero_delay();
    obs_t o;
    run_txn(32'h10, 3'd0, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0, o);
    vectors++; if (o.expired) begin miscompares++; $display("FAIL zero.expired got 1 want 0"); end
    vectors++; if (o.aw_hs !== 1 || o.w_hs !== 1) begin miscompares++; $display("FAIL zero.hs got aw %0d w %0d want 1 1", o.aw_hs, o.w_hs); end
    vectors++; if (o.first_b !== 2) begin miscompares++; $display("FAIL zero.first_b got %0d want 2", o.first_b); end
    vectors++; if (o.first_rsp !== 3) begin miscompares++; $display("FAIL zero.first_rsp got %0d want 3", o.first_rsp); end
    vectors++; if ({o.bresp, o.tmo, o.wait_c} !== 19'd0) begin miscompares++; $display("FAIL zero.rsp got %b/%b/%0d want 00/0/0", o.bresp, o.tmo, o.wait_c); end
    vectors++; if (o.ready_after !== 1'b1 || o.unstable !== 0) begin miscompares++; $display("FAIL zero.after got rdy %b unstable %0d want 1 0", o.ready_after, o.unstable); end
  endtask
  task automatic test_delays();
    obs_t o;
    run_txn(32'h0000_1234, 3'd5, 32'hCAFE_0001, 4'h3, 3, 0, 0, 4, 0, 2'b00, 0, 1'b0, o);
    vectors++; if (o.first_aw !== 4 || o.aw_hs !== 4) begin miscompares++; $display("FAIL delays.aw got first %0d hs %0d want 4 4", o.first_aw, o.aw_hs); end
    vectors++; if (o.first_w !== 1 || o.w_hs !== 5) begin miscompares++; $display("FAIL delays.w got first %0d hs %0d want 1 5", o.first_w, o.w_hs); end
    vectors++; if (o.unstable !== 0) begin miscompares++; $display("FAIL delays.stable got %0d want 0", o.unstable); end
    vectors++; if (o.first_b !== 6) begin miscompares++; $display("FAIL delays.first_b got %0d want 6", o.first_b); end
  endtask
  task automatic test_bresp_delay();
    obs_t o;
    run_txn(32'h20, 3'd1, 32'h5555_AAAA, 4'hA, 0, 0, 0, 0, 7, 2'b10, 0, 1'b0, o);
    vectors++; if ({o.bresp, o.tmo} !== 3'b100) begin miscompares++; $display("FAIL bdelay.rsp got %b/%b want 10/0", o.bresp, o.tmo); end
    vectors++; if (o.wait_c !== 16'd7) begin miscompares++; $display("FAIL bdelay.wait got %0d want 7", o.wait_c); end
    vectors++; if (o.first_rsp !== 10 || o.b_cycles !== 8) begin miscompares++; $display("FAIL bdelay.timing got rsp %0d bcyc %0d want 10 8", o.first_rsp, o.b_cycles); end
  endtask
  task automatic test_timeout();
    obs_t o;
    run_txn(32'h30, 3'd2, 32'h0BAD_F00D, 4'hC, 0, 0, 0, 0, 1000, 2'b00, 3, 1'b1, o);
    vectors++; if (o.b_cycles !== TO) begin miscompares++; $display("FAIL timeout.bready_cycles got %0d want %0d", o.b_cycles, TO); end
    vectors++; if (o.first_rsp !== 2 + TO) begin miscompares++; $display("FAIL timeout.first_rsp got %0d want %0d", o.first_rsp, 2 + TO); end
    vectors++; if ({o.bresp, o.tmo} !== 3'b101) begin miscompares++; $display("FAIL timeout.rsp got %b/%b want 10/1", o.bresp, o.tmo); end
    vectors++; if (o.b_hs !== 0 || o.rsp_unstable !== 0) begin miscompares++; $display("FAIL timeout.late_b got hs %0d unstable %0d want 0 0", o.b_hs, o.rsp_unstable); end
  endtask
  task automatic test_back_to_back();
    obs_t o;
    run_txn(32'h40, 3'd3, 32'h1111_2222, 4'h5, 1, 2, 1, 0, 2, 2'b11, 5, 1'b0, o);
    vectors++; if (o.rsp_unstable !== 0 || o.cmd_bad !== 0) begin miscompares++; $display("FAIL hold.stable got unstable %0d cmd_ready_hits %0d want 0 0", o.rsp_unstable, o.cmd_bad); end
    vectors++; if (o.done !== o.first_rsp + 5 || o.bresp !== 2'b11) begin miscompares++; $display("FAIL hold.done got %0d bresp %b want %0d 11", o.done, o.bresp, o.first_rsp + 5); end
    run_txn(32'h44, 3'd4, 32'h3333_4444, 4'h9, 2, 0, 0, 0, 0, 2'b01, 0, 1'b0, o);
    vectors++; if (o.issue_wait !== 0) begin miscompares++; $display("FAIL b2b.issue_wait got %0d want 0", o.issue_wait); end
    vectors++; if (o.first_aw !== 3 || o.bresp !== 2'b01 || o.first_rsp !== 5) begin miscompares++; $display("FAIL b2b.txn got aw %0d bresp %b rsp %0d want 3 01 5", o.first_aw, o.bresp, o.first_rsp); end
  endtask
  task automatic test_reset_mid();
    obs_t o;
    bus.cmd_valid = 1'b1; bus.cmd_awaddr = 32'hA5A5_0000; bus.cmd_awprot = 3'd7; bus.cmd_wdata = 32'h7777_7777;
    bus.cmd_wstrb = 4'hF; bus.cmd_delay_aw = 5'd0; bus.cmd_delay_w = 5'd2; bus.awready = 1'b0; bus.wready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    vectors++; if (bus.awvalid !== 1'b1 || bus.awaddr !== 32'hA5A5_0000) begin miscompares++; $display("FAIL rstmid.pre got awvalid %b addr %h want 1 a5a50000", bus.awvalid, bus.awaddr); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({bus.cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.rsp_valid} !== 5'b10000) begin miscompares++; $display("FAIL rstmid.ctrl got %b want 10000", {bus.cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.rsp_valid}); end
    vectors++; if ({bus.awaddr, bus.awprot, bus.wdata, bus.wstrb} !== '0) begin miscompares++; $display("FAIL rstmid.data got %h want 0", {bus.awaddr, bus.awprot, bus.wdata, bus.wstrb}); end
    rst = 1'b0;
    @(negedge clk);
    run_txn(32'h50, 3'd0, 32'h0, 4'h1, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0, o);
    vectors++; if (o.first_rsp !== 3 || o.expired) begin miscompares++; $display("FAIL rstmid.recover got rsp %0d want 3", o.first_rsp); end
  endtask
  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      int daw, dw, aws, ws, bd, rs, e_aw, e_w, e_b, e_rsp;
      logic [1:0] br;
      logic [31:0] addr, data;
      bit normal;
      daw = $urandom_range(7, 0); dw = $urandom_range(7, 0); aws = $urandom_range(3, 0); ws = $urandom_range(3, 0);
      bd = $urandom_range(10, 0); rs = $urandom_range(3, 0); br = 2'($urandom); addr = $urandom; data = $urandom;
      run_txn(addr, 3'($urandom), data, 4'($urandom), daw, dw, aws, ws, bd, br, rs, 1'($urandom), o);
      e_aw = 1 + daw;
      e_w = 1 + dw;
      e_b = (e_aw + aws > e_w + ws ? e_aw + aws : e_w + ws) + 1;
      normal = bd < TO;
      e_rsp = e_b + (normal ? bd + 1 : TO);
      vectors++; if (o.first_aw !== e_aw || o.first_w !== e_w) begin miscompares++; $display("FAIL rand%0d.valid got aw %0d w %0d want %0d %0d", i, o.first_aw, o.first_w, e_aw, e_w); end
      vectors++; if (o.first_b !== e_b || o.first_rsp !== e_rsp) begin miscompares++; $display("FAIL rand%0d.resp_timing got b %0d rsp %0d want %0d %0d", i, o.first_b, o.first_rsp, e_b, e_rsp); end
      vectors++; if (o.bresp !== (normal ? br : 2'b10) || o.tmo !== !normal) begin miscompares++; $display("FAIL rand%0d.rsp got %b/%b want %b/%b", i, o.bresp, o.tmo, normal ? br : 2'b10, !normal); end
      if (normal) begin vectors++; if (o.wait_c !== 16'(bd)) begin miscompares++; $display("FAIL rand%0d.wait got %0d want %0d", i, o.wait_c, bd); end end
      vectors++; if (o.unstable + o.rsp_unstable + o.cmd_bad !== 0 || o.done !== e_rsp + rs || o.ready_after !== 1'b1) begin miscompares++; $display("FAIL rand%0d.protocol got unstable %0d/%0d cmd %0d done %0d rdy %b want 0/0 0 %0d 1", i, o.unstable, o.rsp_unstable, o.cmd_bad, o.done, o.ready_after, e_rsp + rs); end
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_awaddr = '0; bus.cmd_awprot = '0; bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
    bus.cmd_delay_aw = '0; bus.cmd_delay_w = '0; bus.rsp_ready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bresp = '0; bus.bvalid = 1'b0;
    test_reset();
    test_zero_delay();
    test_delays();
    test_bresp_delay();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
